// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types and clamp helper for the Sobel threshold controller
package sobel_pkg;

  localparam int TH_W = 21;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    EVAL  = 2'd1,
    APPLY = 2'd2
  } state_t;

  // Signed intermediate so that underflow from a negative step clamps low.
  function automatic logic [TH_W-1:0] clamp_th(
    input logic signed [TH_W+1:0] val,
    input logic        [TH_W-1:0] lo,
    input logic        [TH_W-1:0] hi
  );
    logic signed [TH_W+1:0] lo_s;
    logic signed [TH_W+1:0] hi_s;
    lo_s = $signed({2'b00, lo});
    hi_s = $signed({2'b00, hi});
    if (val < lo_s)
      clamp_th = lo;
    else if (val > hi_s)
      clamp_th = hi;
    else
      clamp_th = val[TH_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_frame_stat.sv
// rtl/sobel_frame_stat.sv - vsync edge detect and saturating per-frame edge-pixel counter
module sobel_frame_stat
  import sobel_pkg::*;
#(
  parameter int CNT_W = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sobel_vs,
  input  logic             sobel_de,
  input  logic [7:0]       sobel_data,
  input  logic             snap_en,
  output logic             vs_rise,
  output logic [CNT_W-1:0] edge_count
);

  logic             vs_r;
  logic [CNT_W-1:0] cnt;
  logic             is_edge;

  assign vs_rise = sobel_vs & ~vs_r;
  assign is_edge = sobel_de && (sobel_data == 8'h00);

  // Counting never stops; only the snapshot is gated so an ignored vsync keeps the frame intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r       <= 1'b0;
      cnt        <= '0;
      edge_count <= '0;
    end else begin
      vs_r <= sobel_vs;
      if (vs_rise && snap_en) begin
        edge_count <= cnt;
        cnt        <= '0;
      end else if (is_edge && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sobel_thresh_ctrl.sv
// rtl/sobel_thresh_ctrl.sv - frame-synchronous threshold controller for the Sobel edge stage
module sobel_thresh_ctrl
  import sobel_pkg::*;
#(
  parameter logic [TH_W-1:0] TH_INIT = 21'd150,
  parameter logic [TH_W-1:0] TH_MIN  = 21'd16,
  parameter logic [TH_W-1:0] TH_MAX  = 21'd2040,
  parameter logic [TH_W-1:0] TH_STEP = 21'd8,
  parameter int              CNT_W   = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sobel_vs,
  input  logic             sobel_de,
  input  logic [7:0]       sobel_data,
  input  logic             inc_req,
  input  logic             dec_req,
  input  logic             cfg_wr,
  input  logic [TH_W-1:0]  cfg_wdata,
  input  logic             auto_en,
  input  logic [CNT_W-1:0] edge_lo,
  input  logic [CNT_W-1:0] edge_hi,
  output logic [TH_W-1:0]  threshold,
  output logic [CNT_W-1:0] edge_count,
  output logic             frame_done,
  output logic             stat_valid
);

  state_t state_q, state_d;

  logic                   vs_rise;
  logic                   snap_en;
  logic                   first_seen;
  logic                   load_pend, load_pend_d;
  logic [TH_W-1:0]        load_val, load_val_d;
  logic signed [4:0]      delta, delta_d;
  logic                   lp_base;
  logic signed [4:0]      d_base;
  logic [TH_W-1:0]        th_next;
  logic [TH_W-1:0]        th_calc;
  logic signed [TH_W+1:0] sum;
  logic signed [TH_W+1:0] delta_ext;
  logic signed [TH_W+1:0] step_ext;

  assign snap_en = (state_q == RUN);

  sobel_frame_stat #(.CNT_W(CNT_W)) u_stat (
    .clk        (clk),
    .rst_n      (rst_n),
    .sobel_vs   (sobel_vs),
    .sobel_de   (sobel_de),
    .sobel_data (sobel_data),
    .snap_en    (snap_en),
    .vs_rise    (vs_rise),
    .edge_count (edge_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (vs_rise) state_d = EVAL;
      EVAL:    state_d = APPLY;
      APPLY:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Pending requests are consumed when th_next is captured, so requests seen in EVAL land next frame.
  always_comb begin
    lp_base     = load_pend;
    d_base      = delta;
    if (state_q == EVAL) begin
      lp_base = 1'b0;
      d_base  = 5'sd0;
    end
    load_pend_d = lp_base;
    load_val_d  = load_val;
    delta_d     = d_base;
    if (cfg_wr) begin
      load_pend_d = 1'b1;
      load_val_d  = cfg_wdata;
      delta_d     = 5'sd0;
    end else if (!lp_base && inc_req && !dec_req && (d_base != 5'sd15)) begin
      delta_d = d_base + 5'sd1;
    end else if (!lp_base && dec_req && !inc_req && (d_base != -5'sd15)) begin
      delta_d = d_base - 5'sd1;
    end
  end

  always_comb begin
    delta_ext = {{(TH_W-3){delta[4]}}, delta};
    step_ext  = {2'b00, TH_STEP};
    sum       = {2'b00, threshold};
    if (load_pend)
      sum = {2'b00, load_val};
    else if (delta != 5'sd0)
      sum = {2'b00, threshold} + delta_ext * step_ext;
    else if (auto_en && stat_valid) begin
      if (edge_count > edge_hi)
        sum = {2'b00, threshold} + step_ext;
      else if (edge_count < edge_lo)
        sum = {2'b00, threshold} - step_ext;
    end
    th_calc = clamp_th(sum, TH_MIN, TH_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      first_seen <= 1'b0;
      stat_valid <= 1'b0;
      load_pend  <= 1'b0;
      load_val   <= '0;
      delta      <= 5'sd0;
      th_next    <= TH_INIT;
      threshold  <= TH_INIT;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_pend  <= load_pend_d;
      load_val   <= load_val_d;
      delta      <= delta_d;
      frame_done <= 1'b0;
      if ((state_q == RUN) && vs_rise) begin
        first_seen <= 1'b1;
        stat_valid <= first_seen;
      end
      if (state_q == EVAL)
        th_next <= th_calc;
      if (state_q == APPLY) begin
        threshold  <= th_next;
        frame_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sobel_thresh_ctrl.sv
// tb/tb_sobel_thresh_ctrl.sv - directed table-driven bench for sobel_thresh_ctrl
module tb_sobel_thresh_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sobel_vs, sobel_de;
  logic [7:0]  sobel_data;
  logic        inc_req, dec_req, cfg_wr, auto_en;
  logic [20:0] cfg_wdata;
  logic [21:0] edge_lo, edge_hi;
  logic [20:0] threshold;
  logic [21:0] edge_count;
  logic        frame_done, stat_valid;

  int total = 0;
  int bad   = 0;
  int cur_th;

  typedef struct {
    int n_edges;
    int n_inc;
    int n_dec;
    int n_both;
    bit do_cfg;
    int cfg_val;
    int n_inc2;
    bit auto_on;
    int exp_th;
    int exp_cnt;
    bit exp_sv;
  } vec_t;

  vec_t vecs[19];

  sobel_thresh_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sobel_vs   (sobel_vs),
    .sobel_de   (sobel_de),
    .sobel_data (sobel_data),
    .inc_req    (inc_req),
    .dec_req    (dec_req),
    .cfg_wr     (cfg_wr),
    .cfg_wdata  (cfg_wdata),
    .auto_en    (auto_en),
    .edge_lo    (edge_lo),
    .edge_hi    (edge_hi),
    .threshold  (threshold),
    .edge_count (edge_count),
    .frame_done (frame_done),
    .stat_valid (stat_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int ne, int ni, int nd, int nb, bit dc, int cv, int ni2,
                              bit au, int eth, int ec, bit sv);
    vec_t v;
    v.n_edges = ne; v.n_inc = ni; v.n_dec = nd; v.n_both = nb;
    v.do_cfg = dc; v.cfg_val = cv; v.n_inc2 = ni2; v.auto_on = au;
    v.exp_th = eth; v.exp_cnt = ec; v.exp_sv = sv;
    return v;
  endfunction

  task automatic pulse_inc();
    inc_req = 1'b1; tick(); inc_req = 1'b0; tick();
  endtask

  task automatic pulse_dec();
    dec_req = 1'b1; tick(); dec_req = 1'b0; tick();
  endtask

  task automatic pulse_cfg(input int val);
    cfg_wr = 1'b1; cfg_wdata = val[20:0]; tick(); cfg_wr = 1'b0; tick();
  endtask

  // Edge pixels, then non-edge active pixels, then blanking with data 0.
  task automatic frame(input int n);
    for (int i = 0; i < n; i++) begin
      sobel_de = 1'b1; sobel_data = 8'h00; tick();
    end
    for (int i = 0; i < 5; i++) begin
      sobel_de = 1'b1; sobel_data = 8'h55; tick();
    end
    sobel_de = 1'b0; sobel_data = 8'h00;
    repeat (3) tick();
  endtask

  task automatic boundary(input string nm, input int th_old, input int th_new,
                          input int exp_cnt, input bit exp_sv);
    sobel_vs = 1'b1;
    tick();
    chk({nm, ".edge_count"}, edge_count, exp_cnt);
    chk({nm, ".stat_valid"}, stat_valid, exp_sv);
    chk({nm, ".th_n1"}, threshold, th_old);
    tick();
    chk({nm, ".th_n2"}, threshold, th_old);
    chk({nm, ".fd_n2"}, frame_done, 0);
    tick();
    chk({nm, ".th_n3"}, threshold, th_new);
    chk({nm, ".fd_n3"}, frame_done, 1);
    tick();
    chk({nm, ".fd_n4"}, frame_done, 0);
    sobel_vs = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0; sobel_vs = 1'b0; sobel_de = 1'b0; sobel_data = 8'h00;
    inc_req = 1'b0; dec_req = 1'b0; cfg_wr = 1'b0; cfg_wdata = '0;
    auto_en = 1'b0; edge_lo = 22'd50; edge_hi = 22'd200;

    //          edges inc dec both cfg val  inc2 auto  th   cnt  sv
    vecs[0]  = mk(100, 0, 0,  0, 0, 0,    0, 0, 150,  100, 0);
    vecs[1]  = mk(100, 0, 0,  0, 0, 0,    0, 0, 150,  100, 1);
    vecs[2]  = mk(40,  3, 0,  0, 0, 0,    0, 0, 174,  40,  1);
    vecs[3]  = mk(7,   0, 0,  0, 1, 5,    1, 0, 16,   7,   1);
    vecs[4]  = mk(0,   0, 0,  0, 1, 3000, 0, 0, 2040, 0,   1);
    vecs[5]  = mk(3,   0, 0,  0, 1, 1000, 0, 0, 1000, 3,   1);
    vecs[6]  = mk(3,   0, 0,  1, 0, 0,    0, 0, 1000, 3,   1);
    vecs[7]  = mk(3,   0, 2,  0, 0, 0,    0, 0, 984,  3,   1);
    vecs[8]  = mk(3,   0, 20, 0, 0, 0,    0, 0, 864,  3,   1);
    vecs[9]  = mk(3,   3, 0,  0, 1, 500,  2, 0, 500,  3,   1);
    vecs[10] = mk(3,   0, 0,  0, 1, 150,  0, 0, 150,  3,   1);
    vecs[11] = mk(500, 0, 0,  0, 0, 0,    0, 1, 158,  500, 1);
    vecs[12] = mk(120, 0, 0,  0, 0, 0,    0, 1, 158,  120, 1);
    vecs[13] = mk(10,  0, 0,  0, 0, 0,    0, 1, 150,  10,  1);
    vecs[14] = mk(200, 0, 0,  0, 0, 0,    0, 1, 150,  200, 1);
    vecs[15] = mk(201, 0, 0,  0, 0, 0,    0, 1, 158,  201, 1);
    vecs[16] = mk(500, 1, 0,  0, 0, 0,    0, 1, 166,  500, 1);
    vecs[17] = mk(3,   0, 0,  0, 1, 20,   0, 0, 20,   3,   1);
    vecs[18] = mk(3,   0, 1,  0, 0, 0,    0, 0, 16,   3,   1);

    repeat (3) tick();
    chk("rst.threshold", threshold, 150);
    chk("rst.edge_count", edge_count, 0);
    chk("rst.frame_done", frame_done, 0);
    chk("rst.stat_valid", stat_valid, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    cur_th = 150;

    for (int v = 0; v < 19; v++) begin
      auto_en = vecs[v].auto_on;
      for (int k = 0; k < vecs[v].n_inc; k++) pulse_inc();
      for (int k = 0; k < vecs[v].n_dec; k++) pulse_dec();
      for (int k = 0; k < vecs[v].n_both; k++) begin
        inc_req = 1'b1; dec_req = 1'b1; tick();
        inc_req = 1'b0; dec_req = 1'b0; tick();
      end
      if (vecs[v].do_cfg) pulse_cfg(vecs[v].cfg_val);
      for (int k = 0; k < vecs[v].n_inc2; k++) pulse_inc();
      frame(vecs[v].n_edges);
      chk($sformatf("v%0d.mid_frame_th", v), threshold, cur_th);
      boundary($sformatf("v%0d", v), cur_th, vecs[v].exp_th, vecs[v].exp_cnt, vecs[v].exp_sv);
      cur_th = vecs[v].exp_th;
    end
    auto_en = 1'b0;

    // Step request during EVAL is held over to the following boundary.
    frame(4);
    sobel_vs = 1'b1;
    tick();
    inc_req = 1'b1;
    tick();
    inc_req = 1'b0;
    tick();
    chk("eval_req.commit", threshold, 16);
    chk("eval_req.fd", frame_done, 1);
    sobel_vs = 1'b0;
    repeat (3) tick();
    frame(4);
    boundary("eval_req.next", 16, 24, 4, 1);

    // A second vsync rise while in EVAL/APPLY must not snapshot or restart the FSM.
    frame(6);
    sobel_vs = 1'b1; tick();
    sobel_vs = 1'b0; tick();
    sobel_vs = 1'b1; tick();
    chk("vs_ignore.fd", frame_done, 1);
    chk("vs_ignore.cnt", edge_count, 6);
    tick();
    chk("vs_ignore.fd_end", frame_done, 0);
    tick();
    chk("vs_ignore.no_refire", frame_done, 0);
    sobel_vs = 1'b0;
    repeat (3) tick();

    // Asynchronous reset mid-frame discards the pending load.
    pulse_cfg(400);
    frame(30);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.threshold", threshold, 150);
    chk("mid_rst.edge_count", edge_count, 0);
    chk("mid_rst.stat_valid", stat_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    frame(20);
    boundary("post_rst", 150, 150, 20, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
